// File: rtl/scr1_sleep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// scr1_sleep_ctrl_pkg
// Shared types and default sizing for the pipeline WFI sleep controller.
//   type_scr1_sleep_fsm_e : sleep sequencer state encoding (exported on state_o)
//   SCR1_SLEEP_*_DFLT     : default parameter values for scr1_pipe_sleep_ctrl
// ---------------------------------------------------------------------------
package scr1_sleep_ctrl_pkg;

  localparam int unsigned SCR1_SLEEP_DRAIN_W_DFLT     = 8;
  localparam int unsigned SCR1_SLEEP_WAKE_SETTLE_DFLT = 2;
  localparam int unsigned SCR1_SLEEP_SCNT_W_DFLT      = 16;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    DRAIN     = 3'd1,
    SLEEP_REQ = 3'd2,
    SLEEP     = 3'd3,
    WAKE      = 3'd4
  } type_scr1_sleep_fsm_e;

endpackage : scr1_sleep_ctrl_pkg

// File: rtl/scr1_pipe_sleep_ctrl.sv
// ---------------------------------------------------------------------------
// scr1_pipe_sleep_ctrl
// Sequences WFI entry into and exit from pipeline clock-gated sleep. Lives on
// the always-on clock between the EXU/CSR WFI logic and clock control.
//
// Ports
//   clk               always-on clock
//   ctrl_rst_n        asynchronous active-low reset
//   wfi_start_i       single-cycle WFI request from the pipe
//   pipe_idle_i       pipe has no outstanding fetch/LSU transactions
//   irq_pending_i     enabled interrupt pending (wake source)
//   dbg_halt_req_i    debug halt request (wake source)
//   clk_en_i          gated-clock enabled flag from clock control
//   cfg_drain_limit_i drain timeout in cycles, 0 disables the timeout
//   sleep_req_o       clock disable request (high while in SLEEP_REQ)
//   wake_req_o        clock enable request (high while in WAKE)
//   wfi_done_o        one-cycle pulse: WFI finished, pipe resumes
//   drain_abort_o     one-cycle pulse: drain timed out, sleep abandoned
//   state_o           current sequencer state
//   sleep_cnt_o       cycles spent in SLEEP during the last/current sleep
// ---------------------------------------------------------------------------
module scr1_pipe_sleep_ctrl
  import scr1_sleep_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_W     = SCR1_SLEEP_DRAIN_W_DFLT,
  parameter int unsigned WAKE_SETTLE = SCR1_SLEEP_WAKE_SETTLE_DFLT,
  parameter int unsigned SCNT_W      = SCR1_SLEEP_SCNT_W_DFLT
) (
  input  logic                clk,
  input  logic                ctrl_rst_n,
  input  logic                wfi_start_i,
  input  logic                pipe_idle_i,
  input  logic                irq_pending_i,
  input  logic                dbg_halt_req_i,
  input  logic                clk_en_i,
  input  logic [DRAIN_W-1:0]  cfg_drain_limit_i,
  output logic                sleep_req_o,
  output logic                wake_req_o,
  output logic                wfi_done_o,
  output logic                drain_abort_o,
  output logic [2:0]          state_o,
  output logic [SCNT_W-1:0]   sleep_cnt_o
);

  // Settle counter only has to reach WAKE_SETTLE-1; the final clk_en_i cycle
  // is recognised combinationally so RUN is reached after WAKE_SETTLE high
  // cycles inside WAKE.
  localparam int unsigned SETTLE_W = (WAKE_SETTLE < 2) ? 1 : $clog2(WAKE_SETTLE + 1);

  localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(WAKE_SETTLE - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_ZERO  = {DRAIN_W{1'b0}};
  localparam logic [DRAIN_W-1:0]  DRAIN_ONE   = {{(DRAIN_W-1){1'b0}}, 1'b1};
  localparam logic [SCNT_W-1:0]   SCNT_ZERO   = {SCNT_W{1'b0}};
  localparam logic [SCNT_W-1:0]   SCNT_ONE    = {{(SCNT_W-1){1'b0}}, 1'b1};
  localparam logic [SCNT_W-1:0]   SCNT_MAX    = {SCNT_W{1'b1}};

  type_scr1_sleep_fsm_e state_r;
  type_scr1_sleep_fsm_e state_next_s;

  logic [DRAIN_W-1:0]  drain_cnt_r;
  logic [DRAIN_W-1:0]  drain_cnt_next_s;
  logic [SETTLE_W-1:0] settle_cnt_r;
  logic [SETTLE_W-1:0] settle_cnt_next_s;
  logic [SCNT_W-1:0]   sleep_cnt_r;
  logic [SCNT_W-1:0]   sleep_cnt_next_s;

  logic wfi_done_next_s;
  logic drain_abort_next_s;
  logic sleep_req_r;
  logic wake_req_r;
  logic wfi_done_r;
  logic drain_abort_r;

  logic wake_ev_s;
  logic limit_zero_s;

  assign wake_ev_s    = irq_pending_i | dbg_halt_req_i;
  assign limit_zero_s = (cfg_drain_limit_i == DRAIN_ZERO);

  // Next-state, counter and pulse decode for the sleep sequencer.
  always_comb begin
    state_next_s       = state_r;
    drain_cnt_next_s   = drain_cnt_r;
    settle_cnt_next_s  = SETTLE_ZERO;
    sleep_cnt_next_s   = sleep_cnt_r;
    wfi_done_next_s    = 1'b0;
    drain_abort_next_s = 1'b0;

    case (state_r)
      RUN: begin
        if (wfi_start_i) begin
          if (wake_ev_s) begin
            // Wake already pending: WFI completes without leaving RUN.
            wfi_done_next_s = 1'b1;
          end else begin
            state_next_s     = DRAIN;
            drain_cnt_next_s = cfg_drain_limit_i;
          end
        end else begin
          state_next_s = RUN;
        end
      end

      DRAIN: begin
        if (wake_ev_s) begin
          state_next_s    = RUN;
          wfi_done_next_s = 1'b1;
        end else if (pipe_idle_i) begin
          state_next_s = SLEEP_REQ;
        end else if (!limit_zero_s && (drain_cnt_r == DRAIN_ONE)) begin
          state_next_s       = RUN;
          drain_abort_next_s = 1'b1;
        end else if (!limit_zero_s && (drain_cnt_r != DRAIN_ZERO)) begin
          drain_cnt_next_s = drain_cnt_r - DRAIN_ONE;
        end else begin
          drain_cnt_next_s = drain_cnt_r;
        end
      end

      SLEEP_REQ: begin
        // A wake racing the clk_en_i drop wins; wake_req_o re-enables the
        // clock if clock control has already gated it.
        if (wake_ev_s) begin
          state_next_s = WAKE;
        end else if (!clk_en_i) begin
          state_next_s     = SLEEP;
          sleep_cnt_next_s = SCNT_ZERO;
        end else begin
          state_next_s = SLEEP_REQ;
        end
      end

      SLEEP: begin
        if (sleep_cnt_r == SCNT_MAX) begin
          sleep_cnt_next_s = SCNT_MAX;
        end else begin
          sleep_cnt_next_s = sleep_cnt_r + SCNT_ONE;
        end
        if (wake_ev_s) begin
          state_next_s = WAKE;
        end else begin
          state_next_s = SLEEP;
        end
      end

      WAKE: begin
        // Wake is committed on entry; only clk_en_i stability matters here.
        if (clk_en_i && (settle_cnt_r == SETTLE_LAST)) begin
          state_next_s    = RUN;
          wfi_done_next_s = 1'b1;
        end else if (clk_en_i) begin
          settle_cnt_next_s = settle_cnt_r + SETTLE_ONE;
        end else begin
          settle_cnt_next_s = SETTLE_ZERO;
        end
      end

      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state_r       <= RUN;
      drain_cnt_r   <= DRAIN_ZERO;
      settle_cnt_r  <= SETTLE_ZERO;
      sleep_cnt_r   <= SCNT_ZERO;
      sleep_req_r   <= 1'b0;
      wake_req_r    <= 1'b0;
      wfi_done_r    <= 1'b0;
      drain_abort_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      drain_cnt_r   <= drain_cnt_next_s;
      settle_cnt_r  <= settle_cnt_next_s;
      sleep_cnt_r   <= sleep_cnt_next_s;
      sleep_req_r   <= (state_next_s == SLEEP_REQ);
      wake_req_r    <= (state_next_s == WAKE);
      wfi_done_r    <= wfi_done_next_s;
      drain_abort_r <= drain_abort_next_s;
    end
  end

  assign sleep_req_o   = sleep_req_r;
  assign wake_req_o    = wake_req_r;
  assign wfi_done_o    = wfi_done_r;
  assign drain_abort_o = drain_abort_r;
  assign state_o       = state_r;
  assign sleep_cnt_o   = sleep_cnt_r;

endmodule : scr1_pipe_sleep_ctrl

// File: tb/tb_scr1_pipe_sleep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scr1_pipe_sleep_ctrl
// Self-checking bench: directed WFI scenarios followed by randomized traffic,
// compared every cycle against a phase-level reference model. A small clock
// control model answers sleep/wake requests after a configurable latency.
// ---------------------------------------------------------------------------
module tb_scr1_pipe_sleep_ctrl;

  localparam int DW   = 8;
  localparam int WS   = 2;
  localparam int SW   = 5;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk;
  logic          ctrl_rst_n;
  logic          wfi_start_i;
  logic          pipe_idle_i;
  logic          irq_pending_i;
  logic          dbg_halt_req_i;
  logic          clk_en_i;
  logic [DW-1:0] cfg_drain_limit_i;
  logic          sleep_req_o;
  logic          wake_req_o;
  logic          wfi_done_o;
  logic          drain_abort_o;
  logic [2:0]    state_o;
  logic [SW-1:0] sleep_cnt_o;

  scr1_pipe_sleep_ctrl #(
    .DRAIN_W     (DW),
    .WAKE_SETTLE (WS),
    .SCNT_W      (SW)
  ) dut (
    .clk               (clk),
    .ctrl_rst_n        (ctrl_rst_n),
    .wfi_start_i       (wfi_start_i),
    .pipe_idle_i       (pipe_idle_i),
    .irq_pending_i     (irq_pending_i),
    .dbg_halt_req_i    (dbg_halt_req_i),
    .clk_en_i          (clk_en_i),
    .cfg_drain_limit_i (cfg_drain_limit_i),
    .sleep_req_o       (sleep_req_o),
    .wake_req_o        (wake_req_o),
    .wfi_done_o        (wfi_done_o),
    .drain_abort_o     (drain_abort_o),
    .state_o           (state_o),
    .sleep_cnt_o       (sleep_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 run, 1 drain, 2 sleep request, 3 sleep, 4 wake.
  int m_ph, m_age, m_ones, m_slp;
  bit m_done, m_abort;

  // Clock control model.
  bit cc_en;
  int s_age, w_age, lat;
  bit glitch_en;
  int cfg_lim;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_age = 0; m_ones = 0; m_slp = 0;
    m_done = 1'b0; m_abort = 1'b0;
    cc_en = 1'b1; s_age = 0; w_age = 0;
  endtask

  task automatic model_step(input bit w, input bit idle, input bit wk, input bit ce, input int lim);
    m_done  = 1'b0;
    m_abort = 1'b0;
    case (m_ph)
      0: if (w) begin
           if (wk) m_done = 1'b1;
           else begin m_ph = 1; m_age = 0; end
         end
      1: if (wk) begin m_ph = 0; m_done = 1'b1; end
         else if (idle) m_ph = 2;
         else if (lim != 0 && m_age == lim - 1) begin m_ph = 0; m_abort = 1'b1; end
         else m_age++;
      2: if (wk) begin m_ph = 4; m_ones = 0; end
         else if (!ce) begin m_ph = 3; m_slp = 0; end
      3: begin
           m_slp = (m_slp >= SMAX) ? SMAX : m_slp + 1;
           if (wk) begin m_ph = 4; m_ones = 0; end
         end
      4: begin
           m_ones = ce ? m_ones + 1 : 0;
           if (m_ones == WS) begin m_ph = 0; m_done = 1'b1; end
         end
      default: m_ph = 0;
    endcase
  endtask

  function automatic logic [31:0] exp_vec();
    logic [2:0] ph;
    logic [SW-1:0] sc;
    ph = 3'(m_ph);
    sc = SW'(m_slp);
    return {20'd0, ph, (m_ph == 2), (m_ph == 4), m_done, m_abort, sc};
  endfunction

  // One clock: drive inputs, advance model, compare all outputs, update clock control.
  task automatic step(input bit w, input bit idle, input bit irq, input bit dbg);
    wfi_start_i       = w;
    pipe_idle_i       = idle;
    irq_pending_i     = irq;
    dbg_halt_req_i    = dbg;
    clk_en_i          = cc_en;
    cfg_drain_limit_i = DW'(cfg_lim);
    @(posedge clk);
    model_step(w, idle, irq | dbg, cc_en, cfg_lim);
    #1;
    chk("cyc", {20'd0, state_o, sleep_req_o, wake_req_o, wfi_done_o, drain_abort_o, sleep_cnt_o},
        exp_vec());
    s_age = sleep_req_o ? s_age + 1 : 0;
    w_age = wake_req_o  ? w_age + 1 : 0;
    if (s_age > lat) cc_en = 1'b0;
    if (w_age > lat) cc_en = 1'b1;
    if (glitch_en && wake_req_o && cc_en && ($urandom_range(0, 7) == 0)) cc_en = 1'b0;
  endtask

  task automatic run_until(input int ph, input bit idle, input bit irq, input bit dbg,
                           input int budget, input string tag);
    for (int i = 0; i < budget && m_ph != ph; i++) step(1'b0, idle, irq, dbg);
    chk(tag, 32'(state_o), 32'(ph));
  endtask

  int n_wake, n_done, ab_n, ab_at;
  bit slp_seen;

  initial begin
    ctrl_rst_n = 1'b0;
    wfi_start_i = 1'b0; pipe_idle_i = 1'b0; irq_pending_i = 1'b0;
    dbg_halt_req_i = 1'b0; clk_en_i = 1'b1; cfg_drain_limit_i = 8'd0;
    cfg_lim = 0; lat = 1; glitch_en = 1'b0;
    model_reset();
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_outs", {28'd0, sleep_req_o, wake_req_o, wfi_done_o, drain_abort_o}, 32'd0);
    chk("rst_cnt", 32'(sleep_cnt_o), 32'd0);
    @(negedge clk);
    ctrl_rst_n = 1'b1;

    // Basic sleep/wake with minimum clock control latency.
    cfg_lim = 8; lat = 1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("drain_lat", 32'(state_o), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sreq_lat", 32'(sleep_req_o), 32'd1);
    run_until(3, 1'b1, 1'b0, 1'b0, 10, "reach_sleep");
    repeat (19) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("slp_cnt20", 32'(sleep_cnt_o), 32'd20);
    chk("to_wake", 32'(wake_req_o), 32'd1);
    n_wake = 1; n_done = 0;
    for (int i = 0; i < 10 && m_ph != 0; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (state_o == 3'd4) n_wake++;
      n_done += int'(wfi_done_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_done += int'(wfi_done_o);
    chk("wake_len", 32'(n_wake), 32'(WS + 1));
    chk("wake_done", 32'(n_done), 32'd1);
    chk("slp_hold", 32'(sleep_cnt_o), 32'd20);

    // Immediate wake: WFI with interrupt pending.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("imm_state", 32'(state_o), 32'd0);
    chk("imm_done", 32'(wfi_done_o), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("imm_pulse", 32'(wfi_done_o), 32'd0);
    chk("imm_noslp", 32'(sleep_req_o), 32'd0);

    // Drain timeout.
    cfg_lim = 4;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ab_n = 0; ab_at = 0; slp_seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (drain_abort_o) begin ab_n++; ab_at = i; end
      slp_seen |= sleep_req_o;
    end
    chk("abort_cnt", 32'(ab_n), 32'd1);
    chk("abort_at", 32'(ab_at), 32'd4);
    chk("abort_noslp", 32'(slp_seen), 32'd0);
    chk("abort_run", 32'(state_o), 32'd0);

    // Drain without timeout.
    cfg_lim = 0; ab_n = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      ab_n += int'(drain_abort_o);
    end
    chk("nt_noabort", 32'(ab_n), 32'd0);
    chk("nt_drain", 32'(state_o), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("nt_sreq", 32'(state_o), 32'd2);
    run_until(3, 1'b0, 1'b0, 1'b0, 10, "nt_sleep");
    step(1'b0, 1'b0, 1'b1, 1'b0);
    run_until(0, 1'b0, 1'b0, 1'b0, 10, "nt_resume");

    // Race: debug halt in the same cycle clk_en_i drops.
    cfg_lim = 3; lat = 5;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("race_sreq", 32'(state_o), 32'd2);
    cc_en = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("race_state", 32'(state_o), 32'd4);
    chk("race_reqs", {30'd0, wake_req_o, sleep_req_o}, 32'd2);
    run_until(0, 1'b0, 1'b0, 1'b0, 20, "race_resume");
    chk("race_done", 32'(wfi_done_o), 32'd1);

    // Saturation, then asynchronous reset while asleep.
    lat = 1; cfg_lim = 8;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_until(3, 1'b1, 1'b0, 1'b0, 10, "sat_sleep");
    repeat (40) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat", 32'(sleep_cnt_o), 32'(SMAX));
    #2 ctrl_rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_outs", {28'd0, sleep_req_o, wake_req_o, wfi_done_o, drain_abort_o}, 32'd0);
    chk("arst_cnt", 32'(sleep_cnt_o), 32'd0);
    model_reset();
    @(negedge clk);
    ctrl_rst_n = 1'b1;

    // Randomized traffic.
    glitch_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (m_ph == 0) begin
        if ($urandom_range(0, 3) == 0) cfg_lim = int'($urandom_range(0, 6));
        lat = int'($urandom_range(1, 3));
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_scr1_pipe_sleep_ctrl
